// File: rtl/lsu_dfx_quiesce_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_dfx_quiesce_ctrl
//
// Sequences a partial-reconfiguration (DFX) shutdown of the LSU store path.
// When the DFX manager requests reconfiguration, the controller does the
// following in order:
//   1. Blocks new store issue.
//   2. Waits for the store unit, store buffer and AMO buffer to go quiet for
//      QUIET_CYCLES consecutive cycles.
//   3. Decouples the reconfigurable region and acknowledges the manager.
// When the manager reports completion, decouple drops first. Store issue stays
// blocked for SETTLE_CYCLES more cycles before it is released.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   pr_req_i               DFX manager reconfiguration request (level)
//   pr_done_i              DFX manager reconfiguration finished (pulse)
//   pr_ack_o               store path quiesced and decoupled
//   pr_busy_o              controller not idle
//   err_timeout_o          sticky: last drain aborted on timeout
//   shutdown_req_o         to store_unit: block new stores
//   dfx_decouple_o         to store_unit/decoupler: isolate the region
//   st_unit_idle_i         store unit FSM idle
//   store_buffer_empty_i   speculative and commit queues empty
//   no_st_pending_i        no outstanding D$ store
//   amo_pending_i          AMO buffer holds or is executing an AMO
// ---------------------------------------------------------------------------
module lsu_dfx_quiesce_ctrl #(
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned QUIET_CYCLES  = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pr_req_i,
    input  logic pr_done_i,
    output logic pr_ack_o,
    output logic pr_busy_o,
    output logic err_timeout_o,
    output logic shutdown_req_o,
    output logic dfx_decouple_o,
    input  logic st_unit_idle_i,
    input  logic store_buffer_empty_i,
    input  logic no_st_pending_i,
    input  logic amo_pending_i
);

    localparam int unsigned DCNT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int unsigned QCNT_W = $clog2(QUIET_CYCLES + 1);
    localparam int unsigned SCNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [QCNT_W-1:0] QCNT_TARGET = QCNT_W'(QUIET_CYCLES);
    localparam logic [SCNT_W-1:0] SCNT_LAST   = SCNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_QUIESCED,
        ST_SETTLE
    } state_e;

    state_e              state_q, state_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [QCNT_W-1:0]   qcnt_q, qcnt_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic                armed_q, armed_d;
    logic                err_q, err_d;
    logic                shutdown_q, shutdown_d;
    logic                decouple_q, decouple_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;

    logic                quiet;
    logic [QCNT_W-1:0]   qcnt_inc;

    assign quiet = st_unit_idle_i & store_buffer_empty_i & no_st_pending_i & ~amo_pending_i;

    // Next-state logic.
    // armed prevents a request that is still held high after a completed or
    // aborted sequence from starting a new drain. The manager must drop the
    // request for at least one cycle before it can re-arm.
    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        qcnt_d   = qcnt_q;
        scnt_d   = scnt_q;
        armed_d  = armed_q;
        err_d    = err_q;
        qcnt_inc = (qcnt_q == QCNT_TARGET) ? qcnt_q : qcnt_q + QCNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (pr_req_i && armed_q) begin
                    state_d = ST_DRAIN;
                    armed_d = 1'b0;
                    err_d   = 1'b0;
                    qcnt_d  = '0;
                    dcnt_d  = '0;
                end
            end

            ST_DRAIN: begin
                qcnt_d = quiet ? qcnt_inc : '0;
                if (dcnt_q != DCNT_LAST) begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
                // Reaching quiescence wins over a simultaneous timeout or withdraw.
                if (quiet && (qcnt_inc == QCNT_TARGET)) begin
                    state_d = ST_QUIESCED;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (!pr_req_i) begin
                    state_d = ST_IDLE;
                end
            end

            // If the request drops here without done, it is a protocol error.
            // The controller ignores it and stays decoupled until done arrives.
            ST_QUIESCED: begin
                if (pr_done_i) begin
                    state_d = ST_SETTLE;
                    scnt_d  = '0;
                end
            end

            ST_SETTLE: begin
                if (scnt_q == SCNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!pr_req_i) begin
            armed_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they are registered.
    // Decoding them this way also keeps decouple inside the shutdown window.
    always_comb begin
        shutdown_d = (state_d != ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        decouple_d = (state_d == ST_QUIESCED);
        ack_d      = (state_d == ST_QUIESCED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            dcnt_q     <= '0;
            qcnt_q     <= '0;
            scnt_q     <= '0;
            armed_q    <= 1'b1;
            err_q      <= 1'b0;
            shutdown_q <= 1'b0;
            decouple_q <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            qcnt_q     <= qcnt_d;
            scnt_q     <= scnt_d;
            armed_q    <= armed_d;
            err_q      <= err_d;
            shutdown_q <= shutdown_d;
            decouple_q <= decouple_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign pr_ack_o       = ack_q;
    assign pr_busy_o      = busy_q;
    assign err_timeout_o  = err_q;
    assign shutdown_req_o = shutdown_q;
    assign dfx_decouple_o = decouple_q;

endmodule
